// File: rtl/data_table_wr_arb.sv
// Hash-table data RAM write port: round-robin arbiter over CH_CNT engines plus a zeroing clear sweep.
// Latency: grant/step to RAM write is one cycle; requests stall while clearing, and the sweep stalls on free_ptr_ready_i.
module data_table_wr_arb #(
    parameter int D_WIDTH     = 64,
    parameter int A_WIDTH     = 10,
    parameter int CH_CNT      = 3,
    parameter int FREE_PTR_EN = 1
) (
    input  logic                        clk_i,
    input  logic                        rst_n_i,
    input  logic [CH_CNT-1:0]           wr_req_i,
    input  logic [CH_CNT*A_WIDTH-1:0]   wr_addr_i,
    input  logic [CH_CNT*D_WIDTH-1:0]   wr_data_i,
    output logic [CH_CNT-1:0]           wr_ack_o,
    input  logic                        clear_run_i,
    output logic                        clear_busy_o,
    output logic                        clear_done_o,
    output logic [A_WIDTH-1:0]          ram_wr_addr_o,
    output logic [D_WIDTH-1:0]          ram_wr_data_o,
    output logic                        ram_wr_en_o,
    output logic [A_WIDTH-1:0]          free_ptr_o,
    output logic                        free_ptr_val_o,
    input  logic                        free_ptr_ready_i
);

    localparam int RW = (CH_CNT > 1) ? $clog2(CH_CNT) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t             state, state_nxt;
    logic [A_WIDTH-1:0] clear_addr, clear_addr_nxt;
    logic [RW-1:0]      rr_ptr, rr_nxt;
    logic               step;
    logic               last_addr;

    logic               gnt_vld;
    logic [RW-1:0]      gnt_idx;
    logic               hi_vld, lo_vld;
    logic [RW-1:0]      hi_idx, lo_idx;
    logic [A_WIDTH-1:0] gnt_addr;
    logic [D_WIDTH-1:0] gnt_data;

    assign clear_busy_o   = (state == CLEAR);
    assign free_ptr_o     = (FREE_PTR_EN != 0) ? clear_addr : '0;
    assign free_ptr_val_o = clear_busy_o && (FREE_PTR_EN != 0);
    assign step           = clear_busy_o && ((FREE_PTR_EN == 0) || free_ptr_ready_i);
    assign last_addr      = (clear_addr == {A_WIDTH{1'b1}});

    // A clear_run_i pulse mid-sweep restarts from address 0 without leaving CLEAR.
    always_comb begin
        state_nxt      = state;
        clear_addr_nxt = clear_addr;
        case (state)
            IDLE: begin
                if (clear_run_i) begin
                    state_nxt      = CLEAR;
                    clear_addr_nxt = '0;
                end
            end
            CLEAR: begin
                if (clear_run_i) begin
                    clear_addr_nxt = '0;
                end else if (step) begin
                    clear_addr_nxt = clear_addr + 1'b1;
                    if (last_addr) begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Lowest requester at or above rr_ptr wins; otherwise wrap to the lowest requester overall.
    always_comb begin
        hi_vld   = 1'b0;
        hi_idx   = '0;
        lo_vld   = 1'b0;
        lo_idx   = '0;
        gnt_vld  = 1'b0;
        gnt_idx  = '0;
        wr_ack_o = '0;
        gnt_addr = '0;
        gnt_data = '0;
        rr_nxt   = rr_ptr;
        for (int k = CH_CNT - 1; k >= 0; k--) begin
            if (wr_req_i[k]) begin
                if (k >= int'(rr_ptr)) begin
                    hi_vld = 1'b1;
                    hi_idx = RW'(k);
                end
                lo_vld = 1'b1;
                lo_idx = RW'(k);
            end
        end
        if ((state == IDLE) && !clear_run_i && lo_vld) begin
            gnt_vld           = 1'b1;
            gnt_idx           = hi_vld ? hi_idx : lo_idx;
            wr_ack_o[gnt_idx] = 1'b1;
            gnt_addr          = wr_addr_i[gnt_idx*A_WIDTH +: A_WIDTH];
            gnt_data          = wr_data_i[gnt_idx*D_WIDTH +: D_WIDTH];
            rr_nxt            = (gnt_idx == RW'(CH_CNT - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state         <= IDLE;
            clear_addr    <= '0;
            rr_ptr        <= '0;
            ram_wr_en_o   <= 1'b0;
            ram_wr_addr_o <= '0;
            ram_wr_data_o <= '0;
            clear_done_o  <= 1'b0;
        end else begin
            state        <= state_nxt;
            clear_addr   <= clear_addr_nxt;
            clear_done_o <= step && last_addr && !clear_run_i;
            if (step) begin
                ram_wr_en_o   <= 1'b1;
                ram_wr_addr_o <= clear_addr;
                ram_wr_data_o <= '0;
            end else if (gnt_vld) begin
                ram_wr_en_o   <= 1'b1;
                ram_wr_addr_o <= gnt_addr;
                ram_wr_data_o <= gnt_data;
                rr_ptr        <= rr_nxt;
            end else begin
                ram_wr_en_o <= 1'b0;
            end
        end
    end

endmodule
